uart_rx_cfg: RTL and testbench

Parametrised asynchronous serial receiver, successor to the fixed 8N1 receiver. Runtime-fixed, elaboration-configurable frame format: data width, parity mode, stop-bit count and oversampling ratio. Adds mid-bit majority voting, parity/framing/break detection and a valid/ready output holding register with overrun reporting. Sits between the board RX pin and the command/packet layer.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_cfg_if.sv | 22 ++
 rtl/uart_baud_tick.sv | 27 ++
 rtl/uart_rx_cfg.sv | 164 ++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver FSM states and the
// majority vote used for mid-bit sampling.
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK_WAIT
    } rx_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Received-word handshake: the receiver is the master, the consumer the slave.
interface uart_rx_cfg_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready;
    logic                 parity_err;
    logic                 frame_err;
    logic                 break_det;
    logic                 overrun;

    modport master (
        output data, valid, parity_err, frame_err, break_det, overrun,
        input  ready
    );

    modport slave (
        input  data, valid, parity_err, frame_err, break_det, overrun,
        output ready
    );
endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick prescaler: one-cycle tick every CLK_DIV clocks, phase
// realigned by reload.
module uart_baud_tick #(
    parameter int unsigned CLK_DIV = 651
) (
    input  logic clk,
    input  logic rst_n,
    input  logic reload,
    output logic tick
);
    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] TOP = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= TOP;
        end else if (reload || cnt == '0) begin
            cnt <= TOP;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tick = (cnt == '0);
endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable oversampling UART receiver with majority voting, parity,
// framing and break detection, and a valid/ready holding register.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 651,
    parameter int unsigned OVERSAMPLE = 8,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rx,
    output logic          busy,
    uart_rx_cfg_if.master bus
);
    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATA_BITS);
    localparam int unsigned M  = OVERSAMPLE / 2;
    localparam logic [TW-1:0] T_A    = TW'(M - 1);
    localparam logic [TW-1:0] T_B    = TW'(M);
    localparam logic [TW-1:0] T_C    = TW'(M + 1);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
    localparam logic S_LAST = (STOP_BITS == 2);
    localparam logic ODD    = (PARITY == PAR_ODD);
    localparam logic PAR_EN = (PARITY == PAR_ODD) || (PARITY == PAR_EVEN);

    logic                 rx_meta, rxs, rxs_prev;
    rx_state_t            state;
    logic [TW-1:0]        tc;
    logic [BW-1:0]        bitcnt;
    logic                 stopcnt, s0, s1, par_bit, perr, ferr;
    logic [DATA_BITS-1:0] shreg;
    logic                 tick, start_edge, vote, in_bit, ferr_fin, brk_fin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta  <= 1'b1;
            rxs      <= 1'b1;
            rxs_prev <= 1'b1;
        end else begin
            rx_meta  <= rx;
            rxs      <= rx_meta;
            rxs_prev <= rxs;
        end
    end

    assign start_edge = (state == ST_IDLE) && rxs_prev && !rxs;
    assign vote       = maj3(s0, s1, rxs);
    assign in_bit     = (state == ST_START) || (state == ST_DATA) ||
                        (state == ST_PARITY) || (state == ST_STOP);
    // Final-stop-bit view of the frame, used at the commit tick.
    assign ferr_fin   = ferr | ~vote;
    assign brk_fin    = ferr_fin && (shreg == '0) && ((PARITY == PAR_NONE) || !par_bit);

    uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .reload (start_edge),
        .tick   (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            tc             <= '0;
            bitcnt         <= '0;
            stopcnt        <= 1'b0;
            s0             <= 1'b1;
            s1             <= 1'b1;
            par_bit        <= 1'b0;
            perr           <= 1'b0;
            ferr           <= 1'b0;
            shreg          <= '0;
            busy           <= 1'b0;
            bus.data       <= '0;
            bus.valid      <= 1'b0;
            bus.parity_err <= 1'b0;
            bus.frame_err  <= 1'b0;
            bus.break_det  <= 1'b0;
            bus.overrun    <= 1'b0;
        end else begin
            bus.overrun <= 1'b0;
            if (bus.valid && bus.ready) bus.valid <= 1'b0;
            if (tick && in_bit) begin
                tc <= (tc == T_LAST) ? '0 : tc + 1'b1;
                if (tc == T_A) s0 <= rxs;
                if (tc == T_B) s1 <= rxs;
            end
            case (state)
                ST_IDLE: if (start_edge) begin
                    state   <= ST_START;
                    busy    <= 1'b1;
                    tc      <= '0;
                    perr    <= 1'b0;
                    ferr    <= 1'b0;
                    par_bit <= 1'b0;
                end
                ST_START: if (tick) begin
                    if (tc == T_C && vote) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (tc == T_LAST) begin
                        state  <= ST_DATA;
                        bitcnt <= '0;
                    end
                end
                ST_DATA: if (tick) begin
                    if (tc == T_C) shreg <= {vote, shreg[DATA_BITS-1:1]};
                    if (tc == T_LAST) begin
                        bitcnt <= bitcnt + 1'b1;
                        if (bitcnt == B_LAST) begin
                            stopcnt <= 1'b0;
                            if (PAR_EN) state <= ST_PARITY;
                            else        state <= ST_STOP;
                        end
                    end
                end
                ST_PARITY: if (tick) begin
                    if (tc == T_C) begin
                        par_bit <= vote;
                        perr    <= (^shreg) ^ vote ^ ODD;
                    end
                    if (tc == T_LAST) state <= ST_STOP;
                end
                ST_STOP: if (tick) begin
                    if (tc == T_LAST) stopcnt <= 1'b1;
                    if (tc == T_C) begin
                        if (stopcnt == S_LAST) begin
                            if (!bus.valid || bus.ready) begin
                                bus.data       <= shreg;
                                bus.valid      <= 1'b1;
                                bus.parity_err <= perr;
                                bus.frame_err  <= ferr_fin;
                                bus.break_det  <= brk_fin;
                            end else begin
                                bus.overrun <= 1'b1;
                            end
                            if (brk_fin) state <= ST_BREAK_WAIT;
                            else         state <= ST_IDLE;
                            busy <= brk_fin;
                            tc   <= '0;
                        end else begin
                            ferr <= ferr_fin;
                        end
                    end
                end
                ST_BREAK_WAIT: if (tick) begin
                    if (!rxs) begin
                        tc <= '0;
                    end else if (tc == T_LAST) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        tc <= tc + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: an 8N1 and a 7E2 instance driven with table,
// hand-written and random frames, checked against expected words.
module tb_uart_rx_cfg;
    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned OS      = 8;
    localparam int BIT = CLK_DIV * OS;

    typedef struct { logic [8:0] data; logic perr; logic ferr; logic brk; } exp_t;
    typedef struct { logic [6:0] d; logic p; logic s1; logic s2;
                     logic [6:0] ed; logic eperr; logic eferr; } vec7_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rx8   = 1'b1;
    logic rx7   = 1'b1;
    logic busy8, busy7;
    int   n_chk = 0, n_pass = 0, acc8 = 0, acc7 = 0, ov8 = 0;
    bit   mon_en = 1'b1;
    exp_t q8[$];
    exp_t q7[$];
    exp_t e8, e7;
    vec7_t tbl[6];

    uart_rx_cfg_if #(.DATA_BITS(8)) b8 ();
    uart_rx_cfg_if #(.DATA_BITS(7)) b7 ();

    uart_rx_cfg #(.CLK_DIV(CLK_DIV), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .rx(rx8), .busy(busy8), .bus(b8.master));
    uart_rx_cfg #(.CLK_DIV(CLK_DIV), .OVERSAMPLE(OS), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut7 (
        .clk(clk), .rst_n(rst_n), .rx(rx7), .busy(busy7), .bus(b7.master));

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, checks so far %0d", n_chk);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Serial frame onto rx8: optional 4-clock inversion near mid-bit, a
    // one-cycle ready pulse aligned to the stop-bit decision, or an abort
    // by reset in the middle of a chosen bit.
    task automatic send8(input logic [7:0] d, input logic stopv, input int glitch_bit,
                         input bit rdy_pulse, input int abort_bit);
        logic [9:0] fr;
        fr = {stopv, d, 1'b0};
        for (int b = 0; b < 10; b++) begin
            for (int j = 0; j < BIT; j++) begin
                @(negedge clk);
                if (b == abort_bit && j == BIT / 2) begin
                    rx8   = 1'b1;
                    rst_n = 1'b0;
                    return;
                end
                rx8 = fr[b] ^ (b == glitch_bit && j >= 18 && j < 22);
                if (rdy_pulse && b == 9) b8.ready = (j == 26);
            end
        end
        rx8 = 1'b1;
    endtask

    task automatic send7(input logic [6:0] d, input logic p, input logic s1, input logic s2);
        logic [10:0] fr;
        fr = {s2, s1, p, d, 1'b0};
        for (int b = 0; b < 11; b++) begin
            for (int j = 0; j < BIT; j++) begin
                @(negedge clk);
                rx7 = fr[b];
            end
        end
        rx7 = 1'b1;
    endtask

    task automatic push8(input logic [7:0] d, input logic ferr, input logic brk);
        q8.push_back('{{1'b0, d}, 1'b0, ferr, brk});
    endtask

    task automatic wait_acc8(input int target, input string name);
        for (int i = 0; i < 4 * BIT && acc8 < target; i++) @(negedge clk);
        check(name, acc8, target);
    endtask

    task automatic wait_acc7(input int target, input string name);
        for (int i = 0; i < 4 * BIT && acc7 < target; i++) @(negedge clk);
        check(name, acc7, target);
    endtask

    always @(negedge clk) begin
        if (rst_n && b8.overrun) ov8++;
        if (rst_n && b8.valid && b8.ready) begin
            acc8++;
            if (mon_en) begin
                if (q8.size() == 0) begin
                    n_chk++;
                    $display("FAIL dut8 word: got %0h with none expected", b8.data);
                end else begin
                    e8 = q8.pop_front();
                    check("dut8 data", b8.data, e8.data);
                    check("dut8 frame_err", b8.frame_err, e8.ferr);
                    check("dut8 break_det", b8.break_det, e8.brk);
                    check("dut8 parity_err", b8.parity_err, e8.perr);
                end
            end
        end
        if (rst_n && b7.valid && b7.ready) begin
            acc7++;
            if (q7.size() == 0) begin
                n_chk++;
                $display("FAIL dut7 word: got %0h with none expected", b7.data);
            end else begin
                e7 = q7.pop_front();
                check("dut7 data", b7.data, e7.data);
                check("dut7 parity_err", b7.parity_err, e7.perr);
                check("dut7 frame_err", b7.frame_err, e7.ferr);
                check("dut7 break_det", b7.break_det, e7.brk);
            end
        end
    end

    initial begin
        int base;
        logic [7:0] d;
        logic sv;
        int gl;
        int gap;

        // 7E2 vectors: even parity bit is 1 when the data has an odd count of ones.
        tbl[0] = '{7'h41, 1'b1, 1'b1, 1'b1, 7'h41, 1'b1, 1'b0};
        tbl[1] = '{7'h41, 1'b0, 1'b1, 1'b1, 7'h41, 1'b0, 1'b0};
        tbl[2] = '{7'h7F, 1'b1, 1'b1, 1'b1, 7'h7F, 1'b0, 1'b0};
        tbl[3] = '{7'h2A, 1'b0, 1'b1, 1'b1, 7'h2A, 1'b1, 1'b0};
        tbl[4] = '{7'h55, 1'b0, 1'b0, 1'b1, 7'h55, 1'b0, 1'b1};
        tbl[5] = '{7'h01, 1'b1, 1'b1, 1'b0, 7'h01, 1'b0, 1'b1};

        b8.ready = 1'b1;
        b7.ready = 1'b1;
        idle(5);
        check("reset data", b8.data, 0);
        check("reset valid", b8.valid, 0);
        check("reset frame_err", b8.frame_err, 0);
        check("reset break_det", b8.break_det, 0);
        check("reset overrun", b8.overrun, 0);
        check("reset busy", busy8, 0);
        check("reset dut7 valid", b7.valid, 0);
        check("reset dut7 parity_err", b7.parity_err, 0);
        rst_n = 1'b1;
        idle(2 * BIT);

        // Back-to-back frames.
        push8(8'hA5, 1'b0, 1'b0);
        push8(8'h3C, 1'b0, 1'b0);
        base = acc8;
        send8(8'hA5, 1'b1, -1, 1'b0, -1);
        send8(8'h3C, 1'b1, -1, 1'b0, -1);
        wait_acc8(base + 2, "back-to-back count");
        idle(BIT);

        // 7E2 table.
        foreach (tbl[i]) begin
            q7.push_back('{{2'b00, tbl[i].ed}, tbl[i].eperr, tbl[i].eferr, 1'b0});
            base = acc7;
            send7(tbl[i].d, tbl[i].p, tbl[i].s1, tbl[i].s2);
            idle(2 * BIT);
            wait_acc7(base + 1, "dut7 table count");
        end

        // One-tick low glitch on an idle line.
        base = acc8;
        @(negedge clk);
        rx8 = 1'b0;
        idle(4);
        rx8 = 1'b1;
        idle(4);
        check("glitch busy rises", busy8, 1);
        idle(40);
        check("glitch busy returns", busy8, 0);
        check("glitch no word", acc8, base);

        // Single-tick glitch in the middle of data bit 2.
        push8(8'h6B, 1'b0, 1'b0);
        base = acc8;
        send8(8'h6B, 1'b1, 3, 1'b0, -1);
        wait_acc8(base + 1, "mid-bit glitch count");
        idle(BIT);

        // Break: 20 bit times low, then release.
        push8(8'h00, 1'b1, 1'b1);
        base = acc8;
        @(negedge clk);
        rx8 = 1'b0;
        idle(20 * BIT);
        check("break busy held", busy8, 1);
        rx8 = 1'b1;
        idle(BIT / 2);
        check("break busy after release", busy8, 1);
        idle(2 * BIT);
        check("break busy cleared", busy8, 0);
        check("break single commit", acc8, base + 1);
        push8(8'h55, 1'b0, 1'b0);
        send8(8'h55, 1'b1, -1, 1'b0, -1);
        wait_acc8(base + 2, "after-break count");
        idle(BIT);

        // Random frames with occasional bad stop bits and glitches.
        for (int i = 0; i < 40; i++) begin
            d  = 8'($urandom);
            sv = ($urandom_range(0, 7) != 0);
            gl = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 8)) : -1;
            if (i == 5) begin
                d  = 8'h00;
                sv = 1'b0;
            end
            push8(d, !sv, !sv && (d == 8'h00));
            base = acc8;
            send8(d, sv, gl, 1'b0, -1);
            gap = (!sv && d == 8'h00) ? 2 : int'($urandom_range(0, 2));
            idle(gap * BIT);
            wait_acc8(base + 1, "random count");
        end
        idle(2 * BIT);

        // Holding register and overrun with ready low.
        mon_en   = 1'b0;
        b8.ready = 1'b0;
        base     = ov8;
        send8(8'h11, 1'b1, -1, 1'b0, -1);
        idle(BIT);
        check("hold valid", b8.valid, 1);
        check("hold data", b8.data, 8'h11);
        check("hold no overrun", ov8, base);
        send8(8'h22, 1'b1, -1, 1'b0, -1);
        idle(BIT);
        check("overrun valid", b8.valid, 1);
        check("overrun keeps data", b8.data, 8'h11);
        check("overrun pulse count", ov8, base + 1);
        send8(8'h22, 1'b1, -1, 1'b1, -1);
        idle(BIT);
        check("same-cycle accept valid", b8.valid, 1);
        check("same-cycle accept data", b8.data, 8'h22);
        check("same-cycle no overrun", ov8, base + 1);

        // Reset in the middle of data bit 4.
        send8(8'h81, 1'b1, -1, 1'b0, 5);
        #1;
        check("mid-frame reset valid", b8.valid, 0);
        check("mid-frame reset data", b8.data, 0);
        check("mid-frame reset busy", busy8, 0);
        check("mid-frame reset frame_err", b8.frame_err, 0);
        check("mid-frame reset overrun", b8.overrun, 0);
        idle(3);
        rst_n    = 1'b1;
        b8.ready = 1'b1;
        mon_en   = 1'b1;
        idle(BIT);
        base = acc8;
        push8(8'h81, 1'b0, 1'b0);
        send8(8'h81, 1'b1, -1, 1'b0, -1);
        wait_acc8(base + 1, "post-reset count");
        idle(BIT);
        check("dut8 expected words left", q8.size(), 0);
        check("dut7 expected words left", q7.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
